// File: rtl/booth8_pp_gen_if.sv
// Operand and partial-product handshake bundle for booth8_pp_gen.
// slave: in_valid/a/b/pp_ready in, in_ready/pp_valid/pp/pp_idx/pp_last out.
interface booth8_pp_gen_if #(
  parameter int WIDTH = 16
);
  localparam int NG = (WIDTH + 2) / 3;
  localparam int IW = (NG > 1) ? $clog2(NG) : 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        a;
  logic [WIDTH-1:0]        b;
  logic                    pp_valid;
  logic                    pp_ready;
  logic signed [WIDTH+2:0] pp;
  logic [IW-1:0]           pp_idx;
  logic                    pp_last;

  modport master (
    output in_valid, a, b, pp_ready,
    input  in_ready, pp_valid, pp, pp_idx, pp_last
  );

  modport slave (
    input  in_valid, a, b, pp_ready,
    output in_ready, pp_valid, pp, pp_idx, pp_last
  );
endinterface

// File: rtl/booth8_pp_gen.sv
// Sequential radix-8 Booth partial-product generator (3X precomputed).
// Ports: clk, rst (async high), bus (slave): operands in, pp stream out.
module booth8_pp_gen #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  booth8_pp_gen_if.slave bus
);
  localparam int NG = (WIDTH + 2) / 3;
  localparam int PW = WIDTH + 3;
  localparam int BW = 3 * NG;
  localparam int IW = (NG > 1) ? $clog2(NG) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [BW:0]      bz;
  logic [PW-1:0]    x1;
  logic [PW-1:0]    x3;

  logic [BW-1:0]    bext;
  logic [PW-1:0]    ax1;
  logic [PW-1:0]    ax3;
  logic [PW-1:0]    sx1;
  logic [PW-1:0]    sx3;
  logic [IW-1:0]    gsel;
  logic [3:0]       win;
  logic [PW-1:0]    mag;
  logic             neg;
  logic [PW-1:0]    nxt_pp;

  assign bus.in_ready = (state == S_IDLE);
  assign bus.pp_valid = (state == S_EMIT);

  always_comb begin
    bext = {BW{bus.b[WIDTH-1]}};
    bext[WIDTH-1:0] = bus.b;
    ax1 = {PW{a_r[WIDTH-1]}};
    ax1[WIDTH-1:0] = a_r;
    ax3 = ax1 + {ax1[PW-2:0], 1'b0};
  end

  // In PRE the first digit uses the multiples still being registered,
  // so pp is ready the same cycle pp_valid first rises.
  always_comb begin
    sx1 = (state == S_PRE) ? ax1 : x1;
    sx3 = (state == S_PRE) ? ax3 : x3;
    gsel = (state == S_EMIT) ? bus.pp_idx + 1'b1 : '0;
    win = bz[3:0];
    for (int g = 0; g < NG; g++) begin
      if (gsel == IW'(g)) win = bz[3*g +: 4];
    end
  end

  // bz carries an implicit zero below bit 0, so window g is {b2,b1,b0,bm1}.
  always_comb begin
    mag = '0;
    neg = win[3] & ~(&win[2:0]);
    case (win)
      4'b0001, 4'b0010,
      4'b1101, 4'b1110: mag = sx1;
      4'b0011, 4'b0100,
      4'b1011, 4'b1100: mag = {sx1[PW-2:0], 1'b0};
      4'b0101, 4'b0110,
      4'b1001, 4'b1010: mag = sx3;
      4'b0111, 4'b1000: mag = {sx1[PW-3:0], 2'b00};
      default:          mag = '0;
    endcase
    nxt_pp = neg ? (~mag + 1'b1) : mag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      a_r         <= '0;
      bz          <= '0;
      x1          <= '0;
      x3          <= '0;
      bus.pp      <= '0;
      bus.pp_idx  <= '0;
      bus.pp_last <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_r   <= bus.a;
            bz    <= {bext, 1'b0};
            state <= S_PRE;
          end
        end
        S_PRE: begin
          x1          <= ax1;
          x3          <= ax3;
          bus.pp      <= nxt_pp;
          bus.pp_idx  <= '0;
          bus.pp_last <= 1'b0;
          state       <= S_EMIT;
        end
        S_EMIT: begin
          if (bus.pp_ready) begin
            if (bus.pp_last) begin
              bus.pp      <= '0;
              bus.pp_idx  <= '0;
              bus.pp_last <= 1'b0;
              state       <= S_IDLE;
            end else begin
              bus.pp      <= nxt_pp;
              bus.pp_idx  <= bus.pp_idx + 1'b1;
              bus.pp_last <= (bus.pp_idx == IW'(NG - 2));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/booth8_pp_gen.md
# booth8_pp_gen

Sequential radix-8 Booth partial-product generator for the radix-8 Booth multiplier datapath. It accepts one signed multiplicand/multiplier pair through a valid/ready handshake and precomputes the hard multiple 3X in a dedicated cycle. It then streams the recoded partial products, one per cycle, to the downstream 5:3 compressor tree over a second valid/ready handshake. Each partial product is a fully negated two's-complement value with its group index, so the consumer only has to shift by 3×index before compression.

## Interface
- WIDTH, 16, operand width in bits (signed two's complement, WIDTH ≥ 4)
- NG (localparam), ceil(WIDTH/3), number of radix-8 groups / partial products
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  signed multiplicand
- b  in  WIDTH  signed multiplier
- pp_valid  out  1  partial product valid
- pp_ready  in  1  downstream accepts partial product
- pp  out  WIDTH+3  signed partial product, digit×a, unshifted
- pp_idx  out  clog2(NG)  group index i (weight 8^i)
- pp_last  out  1  high with the final group (i = NG−1)

## Operation
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- States: IDLE, PRE, EMIT.
- IDLE: in_ready=1. When in_valid=1, the block registers a and b, sign-extended to 3·NG bits (b_ext), and moves to PRE.
- PRE: registers x1 = sext(a) and x3 = 3·sext(a), both WIDTH+3 bits. It loads the group counter with 0 and moves to EMIT. in_ready=0.
- EMIT: pp_valid=1. The digit for group i is formed from b_ext[3i+2], b_ext[3i+1], b_ext[3i], b_ext[3i−1], with b_ext[−1]=0.
  - d = −4·b2 + 2·b1 + b0 + bm1, range −4..+4.
  - Magnitude select: |d| 0→0, 1→x1, 2→x1<<1, 3→x3, 4→x1<<2. Negative d gives the full two's complement. No separate +1 correction bit.
- Handshake on pp_valid && pp_ready:
  - i<NG−1: i increments.
  - i=NG−1: returns to IDLE.
- While pp_ready=0, pp, pp_idx and pp_last hold stable.
- pp_last = (i == NG−1) while in EMIT.
- Registered outputs: pp, pp_idx and pp_last are registered, so they are valid in the same cycle pp_valid is high.
- Derived signals: in_ready = (state==IDLE); pp_valid = (state==EMIT).
- Arithmetic check: the sum over i of pp_i·8^i equals a·b exactly, for all signed inputs including −2^(WIDTH−1) × −2^(WIDTH−1).
- Overlap: a new in_valid during PRE or EMIT is ignored (in_ready=0). Operands must be held by upstream until accepted.

## Timing
- Reset (async assert): state=IDLE, in_ready=1, pp_valid=0, pp=0, pp_idx=0, pp_last=0. All internal registers clear.
- Reset mid-operation: the current product is abandoned immediately and no further pp beats are issued. IDLE is entered on deassertion.
- Latency: operands accepted at edge N. PRE occupies cycle N+1. First pp_valid is high after edge N+2.
- Throughput with pp_ready held high: NG beats on consecutive cycles. in_ready returns to 1 the cycle after the last beat's handshake. One product takes NG+2 cycles; there is no overlap between products.
- Back-to-back: in_valid held high accepts the next pair in the first IDLE cycle.

## Test plan
- Simple product, WIDTH=16 (NG=6): a=3, b=7, pp_ready=1 -> pp = −3, +3, 0, 0, 0, 0 with idx 0..5, pp_last only on idx 5. First pp_valid 2 cycles after acceptance.
- 3X and ±4 digits: a=1000, b=3 -> pp0=3000, rest 0. a=5, b=4 -> pp0=−20, pp1=5, rest 0.
- Extreme operands: a=b=−32768 -> pp0..pp4=0, pp5=+32768 (fits the 19-bit signed pp), reconstructed product 2^30.
- Backpressure: a=3, b=7, pp_ready low for 3 cycles during idx 1 -> pp=3 and pp_idx=1 held stable. Sequence completes unchanged afterwards. in_ready stays 0 throughout.
- Reset mid-stream: assert rst during idx 2 -> pp_valid=0 and in_ready=1 in the same cycle (async). A following a=−7, b=−9 produces digits reconstructing to 63.
- Random: 10k random signed pairs with random pp_ready -> scoreboard checks Σ pp_i·8^i = a·b, NG beats per product, and pp_last only on the final beat.
